// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch unit
//
// Issues one instruction-memory request at a time, hands each returned word to
// decode with a valid/ready handshake, and follows redirects from the next-PC
// unit. A redirect raised while a request is still in flight cannot cancel
// that request on the bus. Instead, the returned word is discarded and the
// fetch restarts at the redirect target.
//
// Optional feature (macro IFU_ALIGN_CHECK_EN):
//   defined   : a misaligned redirect target sets fetch_err (sticky) and parks
//               the unit in HALT until reset.
//   undefined : fetch_err is tied low and the target's low two bits are
//               forced to zero.
//
// Parameters:
//   RESET_PC     first fetch address after reset
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   redirect     non-sequential fetch request
//   redirect_pc  redirect target (sampled when redirect=1)
//   imem_req     memory request, held until imem_ack
//   imem_addr    memory request address, stable while imem_req=1
//   imem_ack     single-cycle acknowledge, imem_rdata valid with it
//   imem_rdata   instruction word from memory
//   instr        instruction presented to decode
//   pc           address of instr
//   instr_valid  instr/pc valid
//   instr_ready  decode accepts instr
//   fetch_err    misaligned redirect seen (sticky)
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DROP  = 3'd2,
        HOLD  = 3'd3,
        HALT  = 3'd4
    } state_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    state_t      state_r, state_nx_s;
    logic [31:0] fetch_pc_r, fetch_pc_nx_s;
    logic [31:0] pending_pc_r, pending_pc_nx_s;
    logic [31:0] pc_r, pc_nx_s;
    logic [31:0] instr_r, instr_nx_s;
    logic        req_r, valid_r;
    logic        err_r, err_nx_s;
    logic [31:0] target_s;
    logic        bad_align_s;

`ifdef IFU_ALIGN_CHECK_EN
    assign target_s    = redirect_pc;
    assign bad_align_s = redirect & misaligned(redirect_pc);
`else
    logic unused_align_bits_s;
    assign unused_align_bits_s = ^redirect_pc[1:0];
    assign target_s    = {redirect_pc[31:2], 2'b00};
    assign bad_align_s = 1'b0;
`endif

    // Next-state and datapath update for the fetch FSM
    always_comb begin
        state_nx_s      = state_r;
        fetch_pc_nx_s   = fetch_pc_r;
        pending_pc_nx_s = pending_pc_r;
        pc_nx_s         = pc_r;
        instr_nx_s      = instr_r;
        err_nx_s        = err_r;
        case (state_r)
            IDLE: begin
                state_nx_s = FETCH;
            end
            FETCH: begin
                if (bad_align_s) begin
                    err_nx_s   = 1'b1;
                    state_nx_s = HALT;
                end else if (redirect && imem_ack) begin
                    // Data for the old path arrives together with the redirect: drop it.
                    fetch_pc_nx_s = target_s;
                    state_nx_s    = FETCH;
                end else if (redirect) begin
                    // Request is in flight; remember the target and wait it out.
                    pending_pc_nx_s = target_s;
                    state_nx_s      = DROP;
                end else if (imem_ack) begin
                    instr_nx_s    = imem_rdata;
                    pc_nx_s       = fetch_pc_r;
                    fetch_pc_nx_s = fetch_pc_r + 32'd4;
                    state_nx_s    = HOLD;
                end else begin
                    state_nx_s = FETCH;
                end
            end
            DROP: begin
                if (bad_align_s) begin
                    err_nx_s   = 1'b1;
                    state_nx_s = HALT;
                end else if (imem_ack) begin
                    fetch_pc_nx_s = redirect ? target_s : pending_pc_r;
                    state_nx_s    = FETCH;
                end else if (redirect) begin
                    pending_pc_nx_s = target_s;
                    state_nx_s      = DROP;
                end else begin
                    state_nx_s = DROP;
                end
            end
            HOLD: begin
                if (bad_align_s) begin
                    err_nx_s   = 1'b1;
                    state_nx_s = HALT;
                end else if (redirect) begin
                    fetch_pc_nx_s = target_s;
                    state_nx_s    = FETCH;
                end else if (instr_ready) begin
                    state_nx_s = FETCH;
                end else begin
                    state_nx_s = HOLD;
                end
            end
            HALT: begin
                state_nx_s = HALT;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            fetch_pc_r   <= RESET_PC;
            pending_pc_r <= 32'd0;
            pc_r         <= 32'd0;
            instr_r      <= 32'd0;
            req_r        <= 1'b0;
            valid_r      <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            fetch_pc_r   <= fetch_pc_nx_s;
            pending_pc_r <= pending_pc_nx_s;
            pc_r         <= pc_nx_s;
            instr_r      <= instr_nx_s;
            req_r        <= (state_nx_s == FETCH) || (state_nx_s == DROP);
            valid_r      <= (state_nx_s == HOLD);
            err_r        <= err_nx_s;
        end
    end

    // fetch_pc only changes when the outstanding request completes, so it is
    // also the in-flight address during DROP.
    assign imem_addr   = fetch_pc_r;
    assign imem_req    = req_r;
    assign instr_valid = valid_r;
    assign instr       = instr_r;
    assign pc          = pc_r;
    assign fetch_err   = err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch -- self-checking bench for instr_fetch
// Directed scenarios followed by a randomized run, checked against a
// request/delivery-level reference model.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int P_IDLE = 0;
    localparam int P_REQ  = 1;
    localparam int P_HOLD = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        fetch_err;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: what the fetch unit is doing at transaction level
    int          m_phase;     // idle / request outstanding / instruction offered
    logic [31:0] m_addr;      // address of the current/next request
    logic        m_kill;      // current request was overtaken by a redirect
    logic [31:0] m_next;      // where to go once the killed request completes
    logic [31:0] m_hold_pc;   // pc of the instruction offered to decode
    int          delivered;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk1({tag, "_req"}, imem_req, 1'b0);
        chk1({tag, "_valid"}, instr_valid, 1'b0);
        chk1({tag, "_err"}, fetch_err, 1'b0);
        chk({tag, "_addr"}, imem_addr, RST_PC);
        chk({tag, "_pc"}, pc, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
    endtask

    task automatic model_reset();
        m_phase   = P_IDLE;
        m_addr    = RST_PC;
        m_kill    = 1'b0;
        m_next    = 32'd0;
        m_hold_pc = 32'd0;
    endtask

    // full reset from a negedge; returns at a negedge with reset released
    task automatic do_reset(input string tag);
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'd0;
        instr_ready = 1'b0;
        #1;
        chk_reset_vals(tag);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // one clock: check outputs against model, drive inputs, advance model
    task automatic cyc(input logic r, input logic [31:0] t, input logic a_want, input logic y);
        logic        a;
        logic [31:0] tm;
        chk1("req", imem_req, m_phase == P_REQ);
        chk1("valid", instr_valid, m_phase == P_HOLD);
        chk1("err", fetch_err, 1'b0);
        if (m_phase == P_REQ) chk("addr", imem_addr, m_addr);
        if (m_phase == P_HOLD) begin
            chk("pc", pc, m_hold_pc);
            chk("instr", instr, mem(m_hold_pc));
        end
        a           = a_want && (m_phase == P_REQ);
        redirect    = r;
        redirect_pc = t;
        imem_ack    = a;
        imem_rdata  = a ? mem(imem_addr) : $urandom;
        instr_ready = y;
        @(posedge clk);
        tm = t & 32'hFFFF_FFFC;
        case (m_phase)
            P_IDLE: m_phase = P_REQ;
            P_REQ: begin
                if (a) begin
                    if (m_kill || r) begin
                        m_addr = r ? tm : m_next;
                        m_kill = 1'b0;
                    end else begin
                        m_hold_pc = m_addr;
                        m_addr    = m_addr + 32'd4;
                        m_phase   = P_HOLD;
                        delivered++;
                    end
                end else if (r) begin
                    m_kill = 1'b1;
                    m_next = tm;
                end
            end
            P_HOLD: begin
                if (r) begin
                    m_addr  = tm;
                    m_phase = P_REQ;
                end else if (y) begin
                    m_phase = P_REQ;
                end
            end
            default: m_phase = P_IDLE;
        endcase
        @(negedge clk);
    endtask

    initial begin
        delivered = 0;
        @(negedge clk);
        do_reset("rst0");

        // zero-wait streaming with decode always ready
        for (int i = 0; i < 6; i++) cyc(1'b0, 32'd0, 1'b1, 1'b1);
        chk1("stream_valid", instr_valid, 1'b1);
        chk("stream_pc", pc, 32'h0000_3008);

        // redirect while the request is outstanding
        do_reset("rst1");
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b1, 32'h0000_3100, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b1);
        chk("drop_next_addr", imem_addr, 32'h0000_3100);
        chk1("drop_no_valid", instr_valid, 1'b0);

        // decode stalls for 5 cycles, then redirect with ready
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 32'd0, 1'b0, 1'b0);
        chk("stall_instr", instr, mem(32'h0000_3100));
        cyc(1'b1, 32'h0000_3040, 1'b0, 1'b1);
        chk("stall_redir_addr", imem_addr, 32'h0000_3040);

        // wrap-around of the sequential address
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("wrap_pc0", pc, 32'hFFFF_FFFC);
        cyc(1'b0, 32'd0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0);
        chk("wrap_pc1", pc, 32'h0000_0000);

        // misaligned redirect
`ifdef IFU_ALIGN_CHECK_EN
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3002;
        instr_ready = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk1("halt_err", fetch_err, 1'b1);
            chk1("halt_req", imem_req, 1'b0);
            chk1("halt_valid", instr_valid, 1'b0);
            @(negedge clk);
        end
        do_reset("rst_halt");
`else
        cyc(1'b1, 32'h0000_3002, 1'b0, 1'b0);
        chk("misalign_addr", imem_addr, 32'h0000_3000);
        chk1("misalign_err", fetch_err, 1'b0);
`endif

        // reset while dropping, with a late ack during reset
        do_reset("rst2");
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_3200, 1'b0, 1'b0);
        chk1("pre_rst_req", imem_req, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        chk_reset_vals("late_ack");
        reset = 1'b1;
        model_reset();
        cyc(1'b0, 32'd0, 1'b0, 1'b0);
        chk1("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, RST_PC);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic        r;
            logic [31:0] t;
            r = ($urandom_range(0, 5) == 0);
            t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom;
`ifdef IFU_ALIGN_CHECK_EN
            t = t & 32'hFFFF_FFFC;
`endif
            cyc(r, t, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1);
        end
        n_tests++;
        assert (delivered > 20) else begin
            n_fail++;
            $error("FAIL rand_progress: got %0d deliveries expected more than 20", delivered);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have port redirect, input, 1 bit: next-PC unit requests a non-sequential fetch (taken beq, jal, jr).
REQ-005 The module SHALL have port redirect_pc, input, 32 bits: target address, sampled only when redirect=1.
REQ-006 The module SHALL have port imem_req, output, 1 bit: memory request, held high until imem_ack.
REQ-007 The module SHALL have port imem_addr, output, 32 bits: request address, stable while imem_req=1.
REQ-008 The module SHALL have port imem_ack, input, 1 bit: single-cycle acknowledge; imem_rdata is valid in the same cycle.
REQ-009 The module SHALL have port imem_rdata, input, 32 bits: instruction word.
REQ-010 The module SHALL have port instr, output, 32 bits: fetched instruction presented to decode.
REQ-011 The module SHALL have port pc, output, 32 bits: address of instr, used by the next-PC unit.
REQ-012 The module SHALL have port instr_valid, output, 1 bit: instr and pc are valid.
REQ-013 The module SHALL have port instr_ready, input, 1 bit: decode accepts instr when instr_valid=1 and instr_ready=1.
REQ-014 The module SHALL have port fetch_err, output, 1 bit: misaligned redirect detected (see Configuration).

Function
REQ-015 The module SHALL implement the states IDLE, FETCH, DROP, HOLD and HALT; imem_req SHALL be 1 in FETCH and DROP only.
REQ-016 IDLE SHALL go to FETCH on the first rising edge after reset deasserts.
REQ-017 In FETCH, imem_addr SHALL equal fetch_pc.
REQ-018 In FETCH, on imem_ack=1 with redirect=0: instr<=imem_rdata, pc<=fetch_pc, fetch_pc<=fetch_pc+4, and state goes to HOLD.
REQ-019 In FETCH, on redirect=1 with imem_ack=0: pending_pc<=redirect_pc, state goes to DROP, and imem_addr SHALL NOT change.
REQ-020 In FETCH, on redirect=1 with imem_ack=1 in the same cycle: the returned data SHALL be discarded, fetch_pc<=redirect_pc, and state stays FETCH.
REQ-021 In DROP, imem_addr SHALL hold the in-flight address.
REQ-022 In DROP, a further redirect SHALL overwrite pending_pc.
REQ-023 In DROP, on imem_ack the data SHALL be discarded, fetch_pc<=pending_pc (or redirect_pc if redirect=1 that cycle), and state goes to FETCH.
REQ-024 In HOLD, instr_valid SHALL be 1, and instr and pc SHALL remain stable until handshake or redirect.
REQ-025 In HOLD, on instr_ready=1 the state SHALL go to FETCH.
REQ-026 In HOLD, on redirect=1: fetch_pc<=redirect_pc and state goes to FETCH; if instr_ready=1 in the same cycle, the handshake SHALL also count as complete.
REQ-027 instr_valid SHALL be 0 in every state except HOLD.
REQ-028 The fetch_pc increment SHALL be modulo 2^32 (32'hFFFF_FFFC+4 = 32'h0000_0000).
REQ-029 Peak throughput SHALL be one instruction per 2 cycles, with zero-wait memory (ack in the first request cycle).

Reset
REQ-030 While reset=0: state=IDLE, fetch_pc=RESET_PC, pending_pc=0, pc=0, instr=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, fetch_err=0.
REQ-031 Reset asserted mid-transaction SHALL abandon it; a late imem_ack arriving in IDLE SHALL be ignored.

Configuration
REQ-032 Macro IFU_ALIGN_CHECK_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL set fetch_err sticky, move the FSM to HALT (no requests, instr_valid=0), and hold it there until reset.
REQ-033 Macro IFU_ALIGN_CHECK_EN undefined: fetch_err SHALL be tied 0, redirect_pc[1:0] SHALL be forced to 2'b00, and HALT SHALL be unreachable.

Verification
REQ-034 Release reset, ack every request in cycle 1, instr_ready=1 -> imem_addr sequence 3000,3004,3008; pc/instr match each ack; instr_valid every 2nd cycle.
REQ-035 Redirect to 0x3100 in FETCH two cycles before ack -> addr stays 0x3000 until ack, data dropped, next req addr 0x3100, no instr_valid for 0x3000.
REQ-036 HOLD with instr_ready=0 for 5 cycles, then redirect to 0x3040 with instr_ready=1 -> instr stable 5 cycles, next imem_addr 0x3040.
REQ-037 Redirect to 0xFFFF_FFFC, then two acks -> pc sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-038 With IFU_ALIGN_CHECK_EN, redirect_pc=0x3002 -> fetch_err=1 next cycle and imem_req=0 until reset; without the macro, next imem_addr is 0x3000.
REQ-039 Assert reset while in DROP, then pulse imem_ack during reset -> all outputs at reset values; first request after release is at RESET_PC.
